multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU/ALU-control stage: it decodes the latched opcode and drives the 2-bit `ALUOp` consumed by ALU control. It also drives every datapath mux and write enable, one instruction step per state. Memory accesses are stretched by a `mem_ready` handshake, and a retired-instruction counter is kept for the bench.

---
 rtl/multicycle_control_pkg.sv | 40 ++++
 rtl/multicycle_control.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// and the ALUOp/PCSource/ALUSrcB codes that ALU control also decodes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: one instruction step per
// state, memory steps stretched by mem_ready, plus a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t st_q, st_d;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = S_FETCH;
    case (st_q)
      S_IDLE:   st_d = S_FETCH;
      S_FETCH:  st_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW, OP_ADDI: st_d = S_MEMADR;
          OP_R:                  st_d = S_EXEC;
          OP_BEQ:                st_d = S_BRANCH;
          OP_J:                  st_d = S_JUMP;
          default:               st_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   st_d = S_MEMRD;
          OP_SW:   st_d = S_MEMWR;
          OP_ADDI: st_d = S_ADDIWB;
          default: st_d = S_FETCH;
        endcase
      end
      S_MEMRD:  st_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  st_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   st_d = S_ALUWB;
      default:  st_d = S_FETCH;
    endcase
  end

  // Moore decode; only the fetch write-enables and illegal look at inputs.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    illegal     = 1'b0;
    case (st_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH2;
        illegal = !(opcode inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  // An instruction retires on the step that returns to FETCH after completing.
  always_comb begin
    case (st_q)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

  assign state = st_q;

endmodule
